// File: rtl/multiply_accumulate_unit_pkg.sv
// Shared opcode constants, FSM state encoding and opcode decode helpers for the
// multiply-accumulate unit.
package multiply_accumulate_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_t;

    localparam logic [3:0] OP_MUL   = 4'b0000;
    localparam logic [3:0] OP_MLA   = 4'b0001;
    localparam logic [3:0] OP_UMULL = 4'b0100;
    localparam logic [3:0] OP_UMLAL = 4'b0101;
    localparam logic [3:0] OP_SMULL = 4'b0110;
    localparam logic [3:0] OP_SMLAL = 4'b0111;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_MUL, OP_MLA, OP_UMULL, OP_UMLAL, OP_SMULL, OP_SMLAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_long(input logic [3:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/multiply_accumulate_unit_if.sv
// Request/response bundle between a controller (master) and the
// multiply-accumulate unit (slave).
interface multiply_accumulate_unit_if #(parameter int WIDTH = 32);
    logic               start;
    logic               abort;
    logic [3:0]         opcode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   d;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               n_flag;
    logic               z_flag;
    logic               illegal;

    modport master (
        output start, abort, opcode, a, b, c, d,
        input  busy, done, result, n_flag, z_flag, illegal
    );

    modport slave (
        input  start, abort, opcode, a, b, c, d,
        output busy, done, result, n_flag, z_flag, illegal
    );
endinterface

// File: rtl/multiply_accumulate_unit_step.sv
// One radix-2^BITS_PER_CYCLE iteration: adds digit * mcand into the running sum.
// On the last digit of a signed multiply the digit MSB carries negative weight.
module multiply_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [2*WIDTH-1:0]        acc,
    input  logic [2*WIDTH-1:0]        mcand,
    input  logic [BITS_PER_CYCLE-1:0] digit,
    input  logic                      negate_msb,
    output logic [2*WIDTH-1:0]        acc_next
);
    always_comb begin
        acc_next = acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (digit[j]) begin
                if (negate_msb && (j == BITS_PER_CYCLE - 1))
                    acc_next = acc_next - (mcand << j);
                else
                    acc_next = acc_next + (mcand << j);
            end
        end
    end
endmodule

// File: rtl/multiply_accumulate_unit.sv
// Iterative multiply-accumulate unit: retires BITS_PER_CYCLE multiplier bits per
// cycle and presents a held result with N/Z flags.
//   state   | meaning
//   IDLE    | waiting for start; operands captured on accept
//   RUN     | N iterations of the shift/add datapath
//   DONE    | one-cycle done pulse; result/flags already updated
module multiply_accumulate_unit
    import multiply_accumulate_unit_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input logic                        clk,
    input logic                        rst_n,
    multiply_accumulate_unit_if.slave  bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mac_state_t         state, state_next;
    logic [CW-1:0]      count;
    logic [3:0]         op;
    logic [2*WIDTH-1:0] acc, mcand, acc_next, final_value;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] result;
    logic               n_flag, z_flag, illegal;
    logic               accept, finish;

    assign accept = (state == ST_IDLE) && bus.start && !bus.abort;
    assign finish = (state == ST_RUN) && !bus.abort && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = op_legal(bus.opcode) ? ST_RUN : ST_DONE;
            ST_RUN: begin
                if (bus.abort)          state_next = ST_IDLE;
                else if (count == LAST) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    multiply_step #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .digit      (mplier[BITS_PER_CYCLE-1:0]),
        .negate_msb (op_is_signed(op) && (count == LAST)),
        .acc_next   (acc_next)
    );

    // Short forms keep only the low word; the upper half reads as zero.
    assign final_value = op_is_long(op) ? acc_next : {{WIDTH{1'b0}}, acc_next[WIDTH-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            op      <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            result  <= '0;
            n_flag  <= 1'b0;
            z_flag  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (accept) begin
                op     <= bus.opcode;
                count  <= '0;
                mplier <= bus.b;
                mcand  <= op_is_signed(bus.opcode) ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a}
                                                   : {{WIDTH{1'b0}}, bus.a};
                case (bus.opcode)
                    OP_MLA:             acc <= {{WIDTH{1'b0}}, bus.c};
                    OP_UMLAL, OP_SMLAL: acc <= {bus.c, bus.d};
                    default:            acc <= '0;
                endcase
            end else if (state == ST_RUN) begin
                acc    <= acc_next;
                mcand  <= mcand << BITS_PER_CYCLE;
                mplier <= mplier >> BITS_PER_CYCLE;
                count  <= count + CW'(1);
            end

            if (finish) begin
                result  <= final_value;
                n_flag  <= op_is_long(op) ? final_value[2*WIDTH-1] : final_value[WIDTH-1];
                z_flag  <= (final_value == '0);
                illegal <= 1'b0;
            end else if (accept && !op_legal(bus.opcode)) begin
                result  <= '0;
                n_flag  <= 1'b0;
                z_flag  <= 1'b1;
                illegal <= 1'b1;
            end
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DONE);
    assign bus.result  = result;
    assign bus.n_flag  = n_flag;
    assign bus.z_flag  = z_flag;
    assign bus.illegal = illegal;
endmodule
